pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline-stage register for the RISC-V core. It replaces fixed, always-advancing stage registers such as EX/MEM, and supports configurable payload widths, valid/ready back-pressure, synchronous flush and bubble insertion. An optional skid buffer provides full throughput with a registered `in_ready`. A saturating stall counter supports performance analysis.

---
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline-stage register with flush, bubble
// insertion and a saturating stall counter.
// Build option: define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a
// registered in_ready; leave it undefined for a single entry with a
// combinational in_ready.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Main entry: always drives the outputs.
    logic              main_valid_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [TAG_W-1:0]  main_tag_q;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = main_valid_q;
    // Bubbles carry an all-zero control bundle so downstream never acts on them.
    assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    state_e            state_q;
    logic              in_ready_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [TAG_W-1:0]  skid_tag_q;

    assign in_ready = in_ready_q;

    // Skid FSM: the skid entry catches the one input accepted while the
    // output stalls; in_ready is registered and low only in StTwo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StEmpty;
            in_ready_q   <= 1'b1;
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            main_tag_q   <= '0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
        end else if (flush) begin
            state_q      <= StEmpty;
            in_ready_q   <= 1'b1;
            main_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_ctrl_q  <= in_ctrl;
                        main_data_q  <= in_data;
                        main_tag_q   <= in_tag;
                        main_valid_q <= 1'b1;
                        state_q      <= StOne;
                    end
                end
                StOne: begin
                    if (in_xfer && !out_xfer) begin
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                        skid_tag_q  <= in_tag;
                        in_ready_q  <= 1'b0;
                        state_q     <= StTwo;
                    end else if (out_xfer && !in_xfer) begin
                        main_valid_q <= 1'b0;
                        state_q      <= StEmpty;
                    end else if (in_xfer && out_xfer) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                        main_tag_q  <= in_tag;
                    end
                end
                StTwo: begin
                    if (out_xfer) begin
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                        main_tag_q  <= skid_tag_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= StOne;
                    end
                end
                default: begin
                    state_q      <= StEmpty;
                    in_ready_q   <= 1'b1;
                    main_valid_q <= 1'b0;
                end
            endcase
        end
    end
`else
    // Single entry: accept when empty or when the held entry leaves this cycle.
    assign in_ready = !main_valid_q || out_ready;

    // Main entry load / drain; flush drops both held and incoming entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            main_tag_q   <= '0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
        end else if (in_xfer) begin
            main_ctrl_q  <= in_ctrl;
            main_data_q  <= in_data;
            main_tag_q   <= in_tag;
            main_valid_q <= 1'b1;
        end else if (out_xfer) begin
            main_valid_q <= 1'b0;
        end
    end
`endif

    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_valid_q && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed test-plan sequences plus random
// traffic, checked by a queue-based reference model sampled on the falling edge.
module tb_pipe_stage_reg;

    localparam int unsigned CtrlW = 4;
    localparam int unsigned DataW = 64;
    localparam int unsigned TagW  = 5;
    localparam int unsigned CntW  = 4;
`ifdef PIPE_STAGE_SKID_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [CtrlW-1:0] in_ctrl;
    logic [DataW-1:0] in_data;
    logic [TagW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [CtrlW-1:0] out_ctrl;
    logic [DataW-1:0] out_data;
    logic [TagW-1:0]  out_tag;
    logic [CntW-1:0]  stall_cnt;

    pipe_stage_reg #(
        .CTRL_W(CtrlW),
        .DATA_W(DataW),
        .TAG_W (TagW),
        .CNT_W (CntW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .out_tag  (out_tag),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CtrlW-1:0] ctrl;
        logic [DataW-1:0] data;
        logic [TagW-1:0]  tag;
    } ent_t;

    // Reference model: FIFO of accepted entries, capacity Cap.
    ent_t             exp_q[$];
    int               m_cnt;
    logic [DataW-1:0] last_data;
    logic [TagW-1:0]  last_tag;

    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [DataW-1:0] act,
                         input logic [DataW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor/scoreboard: compare DUT outputs to the model, then advance the
    // model to what the upcoming rising edge should produce.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_out_valid", DataW'(out_valid), '0);
            check("rst_out_ctrl", DataW'(out_ctrl), '0);
            check("rst_out_data", out_data, '0);
            check("rst_out_tag", DataW'(out_tag), '0);
            check("rst_stall_cnt", DataW'(stall_cnt), '0);
            check("rst_in_ready", DataW'(in_ready), 64'd1);
            exp_q.delete();
            m_cnt     = 0;
            last_data = '0;
            last_tag  = '0;
        end else begin
            int  sz;
            bit  m_ready;
            ent_t e;
            sz = exp_q.size();
            // Skid: accept whenever not full. Single entry: also when draining.
            m_ready = (sz < Cap) || (Cap == 1 && out_ready);
            check("in_ready", DataW'(in_ready), DataW'(m_ready));
            check("out_valid", DataW'(out_valid), DataW'(sz > 0));
            if (sz > 0) begin
                check("out_ctrl", DataW'(out_ctrl), DataW'(exp_q[0].ctrl));
                check("out_data", out_data, exp_q[0].data);
                check("out_tag", DataW'(out_tag), DataW'(exp_q[0].tag));
            end else begin
                check("bubble_ctrl", DataW'(out_ctrl), '0);
                check("bubble_data", out_data, last_data);
                check("bubble_tag", DataW'(out_tag), DataW'(last_tag));
            end
            check("stall_cnt", DataW'(stall_cnt), DataW'(m_cnt));

            if (sz > 0 && !out_ready && m_cnt < (1 << CntW) - 1) m_cnt++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (sz > 0 && out_ready) void'(exp_q.pop_front());
                if (in_valid && m_ready) begin
                    e.ctrl = in_ctrl;
                    e.data = in_data;
                    e.tag  = in_tag;
                    exp_q.push_back(e);
                end
            end
            if (exp_q.size() > 0) begin
                last_data = exp_q[0].data;
                last_tag  = exp_q[0].tag;
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic cyc(input bit iv, input logic [CtrlW-1:0] c, input logic [TagW-1:0] t,
                       input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = {$urandom, $urandom};
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Streaming, tags 1..8 back to back.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 5'(i), 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-pressure: three stalled cycles with input offered, then drain.
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h3, 5'(10 + i), 1'b0, 1'b0);
        repeat (4) cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while holding two entries, with a live ctrl=F input.
        cyc(1'b1, 4'h1, 5'd20, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 5'd21, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 5'd22, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Reset mid-stream with tag 5 held.
        cyc(1'b1, 4'h5, 5'd5, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= 3; i++) cyc(1'b1, 4'(i), 5'(i), 1'b1, 1'b0);

        // Counter saturation: 20 stalled cycles.
        cyc(1'b1, 4'h7, 5'd9, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 5'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
